// File: rtl/demux_pkg.sv
// Shared constants for demux_buffered: default data width, channel indices and
// the FIFO pointer width rule (one extra wrap bit above the address bits).
package demux_pkg;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 2;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_W = ptr_w(FIFO_DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; rdata shows the head entry directly.
// A push while full is dropped, and a pop while empty is ignored.
module sync_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Full means the pointers have lapped each other exactly once.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign wptr_d = do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d = do_pop  ? rptr_q + 1'b1 : rptr_q;
    assign rdata  = mem_q[rptr_q[AW-1:0]];

    // NOTE: storage is reset too, so the head word reads as 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata;
            end
        end
    end

endmodule

// File: rtl/demux_buffered.sv
// 1:2 buffered demux: steers a onto c0 (s=0) or c1 (s=1) through per-channel FIFOs.
// Define ROUTE_COUNT_EN to add the per-channel delivered-word counters cnt0/cnt1.
module demux_buffered
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
`ifdef ROUTE_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c0,
    output logic             c0_valid,
    input  logic             c0_ready,
    output logic [WIDTH-1:0] c1,
    output logic             c1_valid,
    input  logic             c1_ready
`ifdef ROUTE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic empty0, full0, empty1, full1;
    logic push0, push1, pop0, pop1;

    // Room is judged on the start-of-cycle state; a same-cycle pop does not free a slot.
    assign in_ready = (s == CH1) ? !full1 : !full0;

    // in_valid gates first so an undriven s while idle cannot create a push.
    assign push0 = in_valid && in_ready && (s == CH0);
    assign push1 = in_valid && in_ready && (s == CH1);

    assign c0_valid = !empty0;
    assign c1_valid = !empty1;
    assign pop0     = c0_ready && c0_valid;
    assign pop1     = c1_ready && c1_valid;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .wdata (a),
        .pop   (pop0),
        .rdata (c0),
        .empty (empty0),
        .full  (full0)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .wdata (a),
        .pop   (pop1),
        .rdata (c1),
        .empty (empty1),
        .full  (full1)
    );

`ifdef ROUTE_COUNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // Counters wrap naturally at 2^CNT_W.
    assign cnt0_d = pop0 ? cnt0_q + 1'b1 : cnt0_q;
    assign cnt1_d = pop1 ? cnt1_q + 1'b1 : cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    // Without the counters, the delivered-word totals are simply not tracked.
`endif

endmodule

// File: doc/demux_buffered.md
Name: demux_buffered

Overview:
- Inverse of the 2:1 data mux. One 32-bit result stream enters with a select bit, and the word is steered to one of two output channels (c0 for s=0, c1 for s=1).
- Each output channel has its own small FIFO with valid/ready handshakes. A stalled consumer on one channel does not block traffic to the other.
- Sits between the execute/ALU result path and downstream consumers, for example the write-back port and the store-data path.

Parameters:
- WIDTH, 32: data width of the input and both outputs.
- DEPTH, 2: entries per output FIFO; must be a power of 2 and ≥2.
- CNT_W, 16: width of the optional per-channel transfer counters.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- a, input, WIDTH: input data word.
- s, input, 1: channel select (0 → c0, 1 → c1).
- in_valid, input, 1: a/s are valid this cycle.
- in_ready, output, 1: the selected channel can accept a word.
- c0, output, WIDTH: channel 0 head-of-FIFO data.
- c0_valid, output, 1: channel 0 FIFO is not empty.
- c0_ready, input, 1: channel 0 consumer pops this cycle.
- c1, output, WIDTH: channel 1 head-of-FIFO data.
- c1_valid, output, 1: channel 1 FIFO is not empty.
- c1_ready, input, 1: channel 1 consumer pops this cycle.
- cnt0, output, CNT_W: words delivered on c0 (only with ROUTE_COUNT_EN).
- cnt1, output, CNT_W: words delivered on c1 (only with ROUTE_COUNT_EN).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All read/write pointers are set to 0.
  - c0_valid=0, c1_valid=0, c0=0, c1=0.
  - All storage is cleared to 0; counters are 0.
  - Takes effect immediately, even mid-transfer; in-flight words are discarded.
- in_ready:
  - Combinational: in_ready = !full[s].
  - It depends only on the selected FIFO's state at the start of the cycle.
  - A pop on that same FIFO in the same cycle does NOT make room. When the FIFO is full, the push is refused even if the consumer pops.
- Push:
  - Occurs when in_valid && in_ready.
  - a is written to FIFO[s] at the write pointer, and that write pointer increments.
  - The unselected FIFO is untouched.
- Pop:
  - Occurs when cX_valid && cX_ready; the read pointer increments.
  - cX_ready while cX_valid=0 is ignored.
- Latency: a word accepted at edge N is visible on cX with cX_valid=1 after edge N (next cycle), provided the FIFO was empty.
- Ordering: strict FIFO order within each channel. No ordering is guaranteed across channels.
- Pointers:
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
  - empty when wptr==rptr; full when the MSBs differ and the remaining bits are equal.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO: the pop is invalid (valid=0), so only the push takes effect.
- cX is driven directly from storage[rptr], so it is stable while cX_valid=1 and cX_ready=0.
- X on s while in_valid=0 must not alter state.

Optional Feature:
- Macro: ROUTE_COUNT_EN.
- When defined:
  - cnt0/cnt1 increment by 1 on each completed pop of their channel.
  - They wrap from 2^CNT_W−1 to 0.
  - They reset to 0.
- When undefined: cnt0/cnt1 ports are absent and no counter logic is generated.

Decomposition:
- Package demux_pkg holds:
  - DATA_W=32 default.
  - Channel index constants CH0=0, CH1=1.
  - A typedef for the pointer width, derived from DEPTH.
- Sub-module sync_fifo (WIDTH, DEPTH) is instantiated twice.
  - Ports: clk, rst_n, push, wdata, pop, rdata, empty, full.
- The top level contains only the select steering, in_ready, and the counters.

Test Plan:
1. Reset, then a=32'h12345678, s=0, in_valid=1 for one cycle → next cycle c0=32'h12345678, c0_valid=1, c1_valid=0.
2. a=32'h87654321, s=1 with c1_ready=1 → c1=32'h87654321 valid for exactly one cycle. c0 contents stay unchanged.
3. Hold c0_ready=0 and push 3 words on s=0 → first two are accepted, in_ready=0 on the third. Switch s=1 → in_ready=1 and the push to c1 succeeds.
4. Channel 0 full and c0_ready=1 with push on s=0 in the same cycle → the push is refused and the pop happens. The push is accepted next cycle; output order is preserved.
5. Mid-stream, assert rst_n=0 asynchronously between edges → c0_valid/c1_valid drop immediately. After release, both FIFOs are empty.
6. With ROUTE_COUNT_EN and CNT_W=4, deliver 17 words on c1 → cnt1=1 (wrap) and cnt0=0.
